// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - debounced 12-key keypad front end with BCD entry buffer
// Raw one-hot keys are synchronised, debounced into single press events, then assembled into digits.
module keypad_entry_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int DB_CYCLES  = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [11:0]                       key,
   output logic                              key_evt,
   output logic [3:0]                        key_code,
   output logic                              key_held,
   output logic                              multi_err,
   output logic [4*NUM_DIGITS-1:0]           digits,
   output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_cnt,
   output logic                              overflow,
   output logic                              entry_valid,
   output logic [4*NUM_DIGITS-1:0]           entry_value
);
   localparam int CW  = $clog2(DB_CYCLES+1);
   localparam int DCW = $clog2(NUM_DIGITS+1);
   localparam int DW  = 4*NUM_DIGITS;
   localparam logic [CW-1:0]  DB_MAX  = CW'(DB_CYCLES);
   localparam logic [DCW-1:0] DIG_MAX = DCW'(NUM_DIGITS);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   logic [11:0]    r_sync1;
   logic [11:0]    r_ks;
   state_t         r_state;
   state_t         w_state_nxt;
   logic [CW-1:0]  r_cnt;
   logic [CW-1:0]  w_cnt_nxt;
   logic [CW-1:0]  w_cnt_inc;
   logic [3:0]     r_code;
   logic [3:0]     w_code_nxt;
   logic           r_key_evt;
   logic           w_evt_nxt;
   logic [3:0]     r_key_code;
   logic [3:0]     w_key_code_nxt;
   logic           r_inv_prev;
   logic           r_multi_err;
   logic [3:0]     w_ks_code;
   logic           w_ks_zero;
   logic           w_ks_valid;
   logic           w_ks_invalid;
   logic [DW-1:0]  r_digits;
   logic [DW-1:0]  w_digits_shift;
   logic [DCW-1:0] r_digit_cnt;
   logic           r_overflow;
   logic           r_entry_valid;
   logic [DW-1:0]  r_entry_value;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_ks    <= '0;
      end else begin
         r_sync1 <= key;
         r_ks    <= r_sync1;
      end
   end

   assign w_ks_zero    = (r_ks == 12'd0);
   assign w_ks_valid   = $onehot(r_ks);
   assign w_ks_invalid = !w_ks_zero && !w_ks_valid;

   always_comb begin
      w_ks_code = 4'd0;
      for (int i = 0; i < 12; i++) begin
         if (r_ks[i]) w_ks_code = 4'(i);
      end
   end

   assign w_cnt_inc = (r_cnt >= DB_MAX) ? DB_MAX : r_cnt + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_code     <= 4'd0;
         r_key_evt  <= 1'b0;
         r_key_code <= 4'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_code     <= w_code_nxt;
         r_key_evt  <= w_evt_nxt;
         r_key_code <= w_key_code_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_code_nxt     = r_code;
      w_evt_nxt      = 1'b0;
      w_key_code_nxt = r_key_code;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_ks_valid) begin
               w_code_nxt = w_ks_code;
               w_cnt_nxt  = CW'(1);
               // A single-sample debounce accepts the press on the very first valid sample
               if (DB_CYCLES <= 1) begin
                  w_state_nxt    = ST_PRESSED;
                  w_evt_nxt      = 1'b1;
                  w_key_code_nxt = w_ks_code;
               end else begin
                  w_state_nxt = ST_DEBOUNCE;
               end
            end
         end
         ST_DEBOUNCE: begin
            if (w_ks_valid && (w_ks_code == r_code)) begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == DB_MAX) begin
                  w_state_nxt    = ST_PRESSED;
                  w_evt_nxt      = 1'b1;
                  w_key_code_nxt = r_code;
               end
            end else begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         ST_PRESSED: begin
            if (w_ks_zero) begin
               w_cnt_nxt   = CW'(1);
               w_state_nxt = (DB_CYCLES <= 1) ? ST_IDLE : ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (w_ks_zero) begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == DB_MAX) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end
            end else begin
               w_cnt_nxt = CW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inv_prev  <= 1'b0;
         r_multi_err <= 1'b0;
      end else begin
         r_inv_prev  <= w_ks_invalid;
         r_multi_err <= w_ks_invalid && !r_inv_prev;
      end
   end

   // Truncating the concatenation drops the oldest digit and works for a single-digit buffer too
   assign w_digits_shift = DW'({r_digits, r_key_code});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digits      <= '0;
         r_digit_cnt   <= '0;
         r_overflow    <= 1'b0;
         r_entry_valid <= 1'b0;
         r_entry_value <= '0;
      end else begin
         r_overflow    <= 1'b0;
         r_entry_valid <= 1'b0;
         if (r_key_evt) begin
            if (r_key_code <= 4'd9) begin
               if (r_digit_cnt < DIG_MAX) begin
                  r_digits    <= w_digits_shift;
                  r_digit_cnt <= r_digit_cnt + DCW'(1);
               end else begin
                  r_overflow <= 1'b1;
               end
            end else if (r_key_code == 4'hA) begin
               r_digits    <= '0;
               r_digit_cnt <= '0;
            end else if (r_digit_cnt != '0) begin
               r_entry_value <= r_digits;
               r_entry_valid <= 1'b1;
               r_digits      <= '0;
               r_digit_cnt   <= '0;
            end
         end
      end
   end

   assign key_evt     = r_key_evt;
   assign key_code    = r_key_code;
   assign key_held    = (r_state == ST_PRESSED) || (r_state == ST_RELEASE);
   assign multi_err   = r_multi_err;
   assign digits      = r_digits;
   assign digit_cnt   = r_digit_cnt;
   assign overflow    = r_overflow;
   assign entry_valid = r_entry_valid;
   assign entry_value = r_entry_value;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - randomized bench for keypad_entry_ctrl against a run-length model
module tb_keypad_entry_ctrl;
   localparam int ND = 4;
   localparam int DB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [11:0]   key = 12'd0;
   logic          key_evt;
   logic [3:0]    key_code;
   logic          key_held;
   logic          multi_err;
   logic [4*ND-1:0] digits;
   logic [$clog2(ND+1)-1:0] digit_cnt;
   logic          overflow;
   logic          entry_valid;
   logic [4*ND-1:0] entry_value;

   keypad_entry_ctrl #(.NUM_DIGITS(ND), .DB_CYCLES(DB)) dut (
      .clk(clk), .rst_n(rst_n), .key(key),
      .key_evt(key_evt), .key_code(key_code), .key_held(key_held), .multi_err(multi_err),
      .digits(digits), .digit_cnt(digit_cnt), .overflow(overflow),
      .entry_valid(entry_valid), .entry_value(entry_value)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: synchronised samples are a 2-deep delay of the raw key; a press is
   // accepted when the same single key has been seen DB samples in a row while armed, and
   // re-arming needs DB release samples, any bounce restarting the release count at one.
   logic [11:0]     m_pipe[$];
   logic [11:0]     m_prev_ks;
   bit              m_prev_inv;
   int              m_same_run;
   bit              m_armed;
   bit              m_in_rel;
   int              m_rel_cnt;
   bit              m_pend;
   int              m_pend_code;
   int              m_buf[$];
   logic [4*ND-1:0] m_entry;
   bit              e_evt, e_multi, e_ovf, e_valid;
   logic [3:0]      e_code;
   int              m_evts = 0;

   function automatic logic [4*ND-1:0] pack_buf();
      logic [4*ND-1:0] v;
      v = '0;
      foreach (m_buf[i]) v = (v << 4) | (4*ND)'(m_buf[i]);
      return v;
   endfunction

   function automatic logic [3:0] code_of(input logic [11:0] k);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 12; i++) if (k[i]) c = 4'(i);
      return c;
   endfunction

   always @(posedge clk) begin : model
      logic [11:0] ks;
      bit val, inv;
      if (!rst_n) begin
         m_pipe.delete(); m_buf.delete();
         m_prev_ks = '0; m_prev_inv = 0; m_same_run = 0;
         m_armed = 1; m_in_rel = 0; m_rel_cnt = 0; m_pend = 0; m_pend_code = 0;
         m_entry = '0; e_evt = 0; e_multi = 0; e_ovf = 0; e_valid = 0; e_code = 4'd0;
      end else begin
         e_ovf = 0;
         e_valid = 0;
         if (m_pend) begin
            if (m_pend_code <= 9) begin
               if (m_buf.size() < ND) m_buf.push_back(m_pend_code);
               else e_ovf = 1;
            end else if (m_pend_code == 10) begin
               m_buf.delete();
            end else if (m_buf.size() > 0) begin
               m_entry = pack_buf();
               e_valid = 1;
               m_buf.delete();
            end
         end
         m_pipe.push_back(key);
         ks = '0;
         if (m_pipe.size() > 2) ks = m_pipe.pop_front();
         val = ($countones(ks) == 1);
         inv = ($countones(ks) > 1);
         e_multi = inv && !m_prev_inv;
         m_prev_inv = inv;
         m_same_run = !val ? 0 : (ks == m_prev_ks) ? m_same_run + 1 : 1;
         m_prev_ks = ks;
         m_pend = 0;
         e_evt = 0;
         if (m_armed) begin
            if (val && m_same_run >= DB) begin
               e_evt = 1; e_code = code_of(ks); m_armed = 0; m_in_rel = 0;
               m_pend = 1; m_pend_code = int'(code_of(ks)); m_evts++;
            end
         end else if (!m_in_rel) begin
            if (ks == 12'd0) begin m_in_rel = 1; m_rel_cnt = 1; end
         end else begin
            m_rel_cnt = (ks == 12'd0) ? m_rel_cnt + 1 : 1;
         end
         if (!m_armed && m_in_rel && m_rel_cnt >= DB) begin
            m_armed = 1; m_in_rel = 0;
         end
      end
   end

   int dut_evts = 0, dut_multi = 0, dut_ovf = 0, dut_valid = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         chk_eq("key_evt", key_evt, e_evt);
         chk_eq("key_code", key_code, e_code);
         chk_eq("key_held", key_held, !m_armed);
         chk_eq("multi_err", multi_err, e_multi);
         chk_eq("digits", digits, pack_buf());
         chk_eq("digit_cnt", digit_cnt, m_buf.size());
         chk_eq("overflow", overflow, e_ovf);
         chk_eq("entry_valid", entry_valid, e_valid);
         chk_eq("entry_value", entry_value, m_entry);
         if (key_evt) dut_evts++;
         if (multi_err) dut_multi++;
         if (overflow) dut_ovf++;
         if (entry_valid) dut_valid++;
      end
   end

   task automatic hold(input logic [11:0] k, input int n);
      key = k;
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int code);
      hold(12'b1 << code, 10);
      hold(12'd0, 12);
   endtask

   int base_e, base_v, base_o, base_m;

   initial begin
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_eq("rst_evt", key_evt, 0);
      chk_eq("rst_held", key_held, 0);
      chk_eq("rst_digits", digits, 0);
      chk_eq("rst_entry", entry_value, 0);
      rst_n = 1'b1;
      hold(12'd0, 3);

      key = 12'h020;
      repeat (5) @(negedge clk);
      chk_eq("lat_edge5", key_evt, 0);
      @(negedge clk);
      chk_eq("lat_edge6", key_evt, 1);
      chk_eq("lat_code", key_code, 5);
      @(negedge clk);
      chk_eq("lat_edge7", key_evt, 0);
      hold(12'h020, 3);
      hold(12'd0, 12);
      base_e = dut_evts;
      hold(12'h020, 3);
      hold(12'd0, 10);
      chk_eq("glitch_no_evt", dut_evts - base_e, 0);

      press(10);
      base_v = dut_valid;
      press(1); press(2); press(3); press(4); press(11);
      chk_eq("commit_pulse", dut_valid - base_v, 1);
      chk_eq("commit_value", entry_value, 16'h1234);
      chk_eq("commit_cnt", digit_cnt, 0);

      base_o = dut_ovf;
      press(9); press(8); press(7); press(6); press(5);
      chk_eq("ovf_pulse", dut_ovf - base_o, 1);
      chk_eq("ovf_digits", digits, 16'h9876);
      press(10);
      chk_eq("clr_digits", digits, 0);
      chk_eq("clr_cnt", digit_cnt, 0);

      base_m = dut_multi; base_e = dut_evts; base_v = dut_valid;
      hold(12'h009, 10);
      hold(12'd0, 12);
      chk_eq("multi_pulse", dut_multi - base_m, 1);
      chk_eq("multi_no_evt", dut_evts - base_e, 0);
      press(11);
      chk_eq("empty_commit", dut_valid - base_v, 0);
      chk_eq("empty_keep", entry_value, 16'h1234);

      base_e = dut_evts;
      hold(12'h080, 8); hold(12'd0, 2); hold(12'h080, 3); hold(12'd0, 12);
      chk_eq("bounce_one_evt", dut_evts - base_e, 1);

      press(1); press(2);
      key = 12'h080;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_eq("arst_digits", digits, 0);
      chk_eq("arst_cnt", digit_cnt, 0);
      chk_eq("arst_entry", entry_value, 0);
      chk_eq("arst_code", key_code, 0);
      chk_eq("arst_held", key_held, 0);
      key = 12'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base_e = dut_evts;
      hold(12'd0, 15);
      chk_eq("arst_no_evt", dut_evts - base_e, 0);

      for (int s = 0; s < 250; s++) begin
         int r, a, b;
         r = int'($urandom_range(0, 9));
         a = int'($urandom_range(0, 11));
         if (r < 7) begin
            hold(12'b1 << a, int'($urandom_range(1, 9)));
         end else begin
            b = (a + int'($urandom_range(1, 11))) % 12;
            hold((12'b1 << a) | (12'b1 << b), int'($urandom_range(1, 6)));
         end
         hold(12'd0, int'($urandom_range(1, 10)));
      end
      hold(12'd0, 20);
      chk_eq("total_evts", dut_evts, m_evts);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
